// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty flags,
// sticky overflow/underflow errors and an empty-FIFO read/write bypass.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  CLEAR_N,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  WRITE,
  input  logic                  READ,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  F_FULL_N,
  output logic                  F_EMPTY_N,
  output logic                  F_AFULL_N,
  output logic                  F_AEMPTY_N,
  output logic [ADDR_WIDTH:0]   USE_DW,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [1:0]            FSM_STATE
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  if (ADDR_WIDTH < 2) begin : g_bad_addr_width
    $error("fifo_sync_param: ADDR_WIDTH must be at least 2");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
    $error("fifo_sync_param: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH:0]     count, count_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic                    wr_en, rd_en, bypass, set_of, set_uf;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_comb begin
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    bypass = 1'b0;
    set_of = 1'b0;
    set_uf = 1'b0;
    unique case (state)
      EMPTY: begin
        // Simultaneous read and write on an empty FIFO passes the word straight through.
        if (WRITE && READ) bypass = 1'b1;
        else if (WRITE)    wr_en  = 1'b1;
        else if (READ)     set_uf = 1'b1;
      end
      PARTIAL: begin
        wr_en = WRITE;
        rd_en = READ;
      end
      FULL: begin
        rd_en = READ;
        wr_en = WRITE && READ;
        set_of = WRITE && !READ;
      end
      default: ;
    endcase

    count_nxt = count;
    if (wr_en && !rd_en)      count_nxt = count + CNT_ONE;
    else if (rd_en && !wr_en) count_nxt = count - CNT_ONE;

    if (count_nxt == '0)           state_nxt = EMPTY;
    else if (count_nxt == DEPTH_C) state_nxt = FULL;
    else                           state_nxt = PARTIAL;
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[wr_ptr] <= DATA_IN;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= EMPTY;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      DATA_OUT  <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else if (!CLEAR_N) begin
      state     <= EMPTY;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      DATA_OUT  <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        DATA_OUT <= mem[rd_ptr];
      end else if (bypass) begin
        DATA_OUT <= DATA_IN;
      end
      if (set_of) OVERFLOW  <= 1'b1;
      if (set_uf) UNDERFLOW <= 1'b1;
    end
  end

  assign USE_DW     = count;
  assign FSM_STATE  = state;
  assign F_FULL_N   = (state != FULL);
  assign F_EMPTY_N  = (state != EMPTY);
  assign F_AFULL_N  = !(count >= AF_C);
  assign F_AEMPTY_N = !(count <= AE_C);

  a_count_range: assert property (@(posedge CLOCK) disable iff (!RESET_N)
    count <= DEPTH_C);
  a_full_empty_excl: assert property (@(posedge CLOCK) disable iff (!RESET_N)
    !(!F_FULL_N && !F_EMPTY_N));
  // Clear may drop the count arbitrarily; otherwise it moves by at most one.
  a_count_step: assert property (@(posedge CLOCK) disable iff (!RESET_N)
    CLEAR_N |-> (count_nxt == count) || (count_nxt == count + CNT_ONE) ||
                (count == count_nxt + CNT_ONE));

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: default instance driven against a queue model,
// plus a small 16x8 instance checking the parametrised flag thresholds.
module tb_fifo_sync_param;

  logic       CLOCK;
  logic       RESET_N;
  logic       CLEAR_N;
  logic [7:0] DATA_IN;
  logic       WRITE, READ;
  logic [7:0] DATA_OUT;
  logic       F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N;
  logic [5:0] USE_DW;
  logic       OVERFLOW, UNDERFLOW;
  logic [1:0] FSM_STATE;

  logic [15:0] d2_din, d2_dout;
  logic        d2_write, d2_read;
  logic        d2_full_n, d2_empty_n, d2_afull_n, d2_aempty_n;
  logic [3:0]  d2_use_dw;
  logic        d2_of, d2_uf;
  logic [1:0]  d2_state;

  fifo_sync_param dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .CLEAR_N(CLEAR_N), .DATA_IN(DATA_IN),
    .WRITE(WRITE), .READ(READ), .DATA_OUT(DATA_OUT), .F_FULL_N(F_FULL_N),
    .F_EMPTY_N(F_EMPTY_N), .F_AFULL_N(F_AFULL_N), .F_AEMPTY_N(F_AEMPTY_N),
    .USE_DW(USE_DW), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .FSM_STATE(FSM_STATE)
  );

  fifo_sync_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut2 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .CLEAR_N(CLEAR_N), .DATA_IN(d2_din),
    .WRITE(d2_write), .READ(d2_read), .DATA_OUT(d2_dout), .F_FULL_N(d2_full_n),
    .F_EMPTY_N(d2_empty_n), .F_AFULL_N(d2_afull_n), .F_AEMPTY_N(d2_aempty_n),
    .USE_DW(d2_use_dw), .OVERFLOW(d2_of), .UNDERFLOW(d2_uf),
    .FSM_STATE(d2_state)
  );

  // clock / reset
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // scoreboard and model state
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp2_q[$];
  int         m_cnt;
  logic [7:0] m_dout;
  bit         m_of, m_uf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt  = 0;
    m_dout = 8'h00;
    m_of   = 1'b0;
    m_uf   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".use_dw"},   32'(USE_DW),     32'(m_cnt));
    chk({tag, ".data_out"}, 32'(DATA_OUT),   32'(m_dout));
    chk({tag, ".full_n"},   32'(F_FULL_N),   32'(m_cnt != 32));
    chk({tag, ".empty_n"},  32'(F_EMPTY_N),  32'(m_cnt != 0));
    chk({tag, ".afull_n"},  32'(F_AFULL_N),  32'(m_cnt < 28));
    chk({tag, ".aempty_n"}, 32'(F_AEMPTY_N), 32'(m_cnt > 4));
    chk({tag, ".overflow"}, 32'(OVERFLOW),   32'(m_of));
    chk({tag, ".underflow"},32'(UNDERFLOW),  32'(m_uf));
  endtask

  // driver: one clock with the given strobes, model update, then full check
  task automatic cycle(input string tag, input bit wr, input bit rd,
                       input logic [7:0] din, input bit clr_n);
    WRITE   = wr;
    READ    = rd;
    DATA_IN = din;
    CLEAR_N = clr_n;
    @(posedge CLOCK);
    #1;
    if (!clr_n) begin
      model_reset();
    end else if (m_cnt == 0) begin
      if (wr && rd) m_dout = din;
      else if (wr) begin exp_q.push_back(din); m_cnt++; end
      else if (rd) m_uf = 1'b1;
    end else if (m_cnt == 32 && wr && !rd) begin
      m_of = 1'b1;
    end else begin
      if (rd) begin m_dout = exp_q.pop_front(); m_cnt--; end
      if (wr) begin exp_q.push_back(din); m_cnt++; end
    end
    WRITE   = 1'b0;
    READ    = 1'b0;
    CLEAR_N = 1'b1;
    check_all(tag);
  endtask

  initial begin
    RESET_N = 1'b0; CLEAR_N = 1'b1; WRITE = 1'b0; READ = 1'b0; DATA_IN = 8'h00;
    d2_write = 1'b0; d2_read = 1'b0; d2_din = 16'h0000;
    model_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    check_all("reset");
    @(negedge CLOCK);
    RESET_N = 1'b1;

    cycle("bypass", 1'b1, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 32; i++) cycle("fill", 1'b1, 1'b0, 8'(i), 1'b1);
    cycle("overflow", 1'b1, 1'b0, 8'hEE, 1'b1);
    for (int i = 0; i < 32; i++) cycle("drain", 1'b0, 1'b1, 8'h00, 1'b1);
    cycle("underflow", 1'b0, 1'b1, 8'h00, 1'b1);

    for (int i = 0; i < 20; i++) cycle("wrap_w1", 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 20; i++) cycle("wrap_r", 1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) cycle("wrap_w2", 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 12; i++) cycle("top_up", 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 10; i++) cycle("full_rw", 1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 20; i++) cycle("to_12", 1'b0, 1'b1, 8'h00, 1'b1);

    cycle("clear", 1'b1, 1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 12; i++) cycle("refill", 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
    cycle("overflow_chk_pre", 1'b0, 1'b1, 8'h00, 1'b1);

    #2 RESET_N = 1'b0;
    model_reset();
    #1 check_all("async_reset");
    #1 RESET_N = 1'b1;
    cycle("post_rst_w", 1'b1, 1'b0, 8'h3C, 1'b1);
    cycle("post_rst_r", 1'b0, 1'b1, 8'h00, 1'b1);

    // 16-bit x 8 instance
    for (int i = 0; i < 8; i++) begin
      d2_write = 1'b1;
      d2_din   = 16'hB000 + 16'(i);
      exp2_q.push_back(d2_din);
      @(posedge CLOCK);
      #1;
      d2_write = 1'b0;
      chk("p2_use_dw",  32'(d2_use_dw),  32'(i + 1));
      chk("p2_full_n",  32'(d2_full_n),  32'(i + 1 != 8));
      chk("p2_afull_n", 32'(d2_afull_n), 32'(i + 1 < 6));
    end
    d2_write = 1'b1;
    d2_din   = 16'hDEAD;
    @(posedge CLOCK);
    #1;
    d2_write = 1'b0;
    chk("p2_overflow", 32'(d2_of),     32'd1);
    chk("p2_use_dw_full", 32'(d2_use_dw), 32'd8);
    for (int i = 7; i >= 0; i--) begin
      d2_read = 1'b1;
      @(posedge CLOCK);
      #1;
      d2_read = 1'b0;
      chk("p2_data",     32'(d2_dout),     32'(exp2_q.pop_front()));
      chk("p2_aempty_n", 32'(d2_aempty_n), 32'(i > 1));
      chk("p2_empty_n",  32'(d2_empty_n),  32'(i != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO, successor to the fixed 8-bit x 32 FIFO. It generalises data width and depth and adds programmable almost-full/almost-empty flags. It also adds sticky overflow/underflow error flags and a full-range occupancy count. It sits between a producer and a consumer in the same clock domain and is driven by level-sensitive READ/WRITE strobes.

Parameters:
DATA_WIDTH, 8, width of DATA_IN/DATA_OUT in bits
ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH words (default 32)
AF_LEVEL, 28, F_AFULL_N asserts (low) when occupancy >= AF_LEVEL
AE_LEVEL, 4, F_AEMPTY_N asserts (low) when occupancy <= AE_LEVEL

Ports:
CLOCK  in  1  single clock; all logic is rising-edge
RESET_N  in  1  asynchronous, active-low reset
CLEAR_N  in  1  synchronous active-low clear; same effect as reset, at the next edge
DATA_IN  in  DATA_WIDTH  write data
WRITE  in  1  write request
READ  in  1  read request
DATA_OUT  out  DATA_WIDTH  registered read data
F_FULL_N  out  1  low when occupancy == DEPTH
F_EMPTY_N  out  1  low when occupancy == 0
F_AFULL_N  out  1  low when occupancy >= AF_LEVEL
F_AEMPTY_N  out  1  low when occupancy <= AE_LEVEL
USE_DW  out  ADDR_WIDTH+1  occupancy, 0..DEPTH inclusive
OVERFLOW  out  1  sticky: a write was rejected
UNDERFLOW  out  1  sticky: a read was rejected

Behaviour:
- Clock and reset: one clock, CLOCK. Reset RESET_N is asynchronous and active-low.
- Reset values:
  - Pointers and USE_DW = 0.
  - DATA_OUT = 0.
  - F_EMPTY_N = 0, F_AEMPTY_N = 0.
  - F_FULL_N = 1, F_AFULL_N = 1.
  - OVERFLOW = 0, UNDERFLOW = 0.
- CLEAR_N low at an edge: identical result to reset. It takes priority over READ/WRITE in that cycle. RAM contents are don't-care.
- FSM states are EMPTY, PARTIAL and FULL, derived from USE_DW. Flags are decoded from registered state/count, so there are no combinational paths from inputs to flags.
- Accept rules, evaluated at each rising edge:
  - EMPTY, WRITE only: write accepted, USE_DW becomes 1, next state PARTIAL.
  - EMPTY, READ only: rejected; UNDERFLOW set; no state change.
  - EMPTY, READ and WRITE: bypass. DATA_OUT <= DATA_IN at this edge (visible the following cycle). Nothing is stored, USE_DW stays 0, no flag is set.
  - PARTIAL, WRITE only: store at wr_ptr, wr_ptr+1, USE_DW+1. Next state is FULL if USE_DW reaches DEPTH.
  - PARTIAL, READ only: DATA_OUT <= mem[rd_ptr], rd_ptr+1, USE_DW-1. Next state is EMPTY if USE_DW reaches 0.
  - PARTIAL, READ and WRITE: both performed; USE_DW and state unchanged.
  - FULL, WRITE only: rejected; OVERFLOW set; memory is not modified.
  - FULL, READ only: read performed; next state PARTIAL.
  - FULL, READ and WRITE: both performed; stays FULL.
- Read latency: 1 cycle. DATA_OUT updates only on an accepted read or a bypass, and holds its value otherwise.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH with no special handling. USE_DW has one extra bit so that DEPTH is representable.
- Ordering: a word read in the same cycle it is written (PARTIAL with rd_ptr == wr_ptr cannot occur) is never required. Read-during-write to the same address only happens through the bypass path.
- OVERFLOW and UNDERFLOW clear only on reset or CLEAR_N.
- Elaboration-time legality checks:
  - ADDR_WIDTH >= 2.
  - 0 <= AE_LEVEL < AF_LEVEL <= DEPTH.
  - An illegal combination triggers $error.
- Assertions:
  - USE_DW <= DEPTH at all times.
  - F_FULL_N and F_EMPTY_N are never low simultaneously.
  - USE_DW changes by at most 1 per cycle.
- Target size: about 200-300 lines of RTL, with the dual-port RAM inferred inside the module.

Test Plan:
- Reset, then 32 writes of 0x00..0x1F (defaults): USE_DW steps 1..32; F_AFULL_N falls when USE_DW = 28; F_FULL_N falls when USE_DW = 32; F_EMPTY_N rises after the first write.
- From full: a 33rd WRITE-only asserts OVERFLOW with USE_DW still 32. Then 32 reads return 0x00..0x1F in order, each 1 cycle after READ. F_AEMPTY_N falls when USE_DW = 4; F_EMPTY_N falls when USE_DW = 0.
- Empty FIFO with READ=WRITE=1 and DATA_IN = 0xA5: DATA_OUT = 0xA5 the next cycle; USE_DW = 0; no UNDERFLOW.
- Wrap: 20 writes, 20 reads, then 20 writes. The pointers cross 31->0, and the subsequent reads return correct data.
- Full FIFO with READ=WRITE=1 for 10 cycles: USE_DW stays 32, the old words come out in order, and no OVERFLOW is raised.
- Mid-stream clear with USE_DW = 12: CLEAR_N low for 1 cycle clears USE_DW, OVERFLOW and UNDERFLOW and drives F_EMPTY_N low. Repeat the scenario with RESET_N pulsed asynchronously between edges: all outputs go to their reset values immediately.
- Parametrised rerun with DATA_WIDTH=16, ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=1: F_FULL_N falls when USE_DW = 8; F_AFULL_N falls when USE_DW = 6.
